// File: rtl/imuldiv_div_arbiter_if.sv
// Port bundle for imuldiv_div_arbiter: two requester channels plus the shared-divider channel.
// slave = arbiter side, master = requesters/divider side.
interface imuldiv_div_arbiter_if;
  logic        req0_val, req0_rdy, req0_fn;
  logic [31:0] req0_a, req0_b;
  logic        req1_val, req1_rdy, req1_fn;
  logic [31:0] req1_a, req1_b;
  logic        resp0_val, resp0_rdy;
  logic [63:0] resp0_result;
  logic        resp1_val, resp1_rdy;
  logic [63:0] resp1_result;
  logic        divreq_val, divreq_rdy, divreq_msg_fn;
  logic [31:0] divreq_msg_a, divreq_msg_b;
  logic        divresp_val, divresp_rdy;
  logic [63:0] divresp_msg_result;

  modport slave (
    input  req0_val, req0_fn, req0_a, req0_b,
    input  req1_val, req1_fn, req1_a, req1_b,
    input  resp0_rdy, resp1_rdy, divreq_rdy, divresp_val, divresp_msg_result,
    output req0_rdy, req1_rdy, resp0_val, resp0_result, resp1_val, resp1_result,
    output divreq_val, divreq_msg_fn, divreq_msg_a, divreq_msg_b, divresp_rdy
  );

  modport master (
    output req0_val, req0_fn, req0_a, req0_b,
    output req1_val, req1_fn, req1_a, req1_b,
    output resp0_rdy, resp1_rdy, divreq_rdy, divresp_val, divresp_msg_result,
    input  req0_rdy, req1_rdy, resp0_val, resp0_result, resp1_val, resp1_result,
    input  divreq_val, divreq_msg_fn, divreq_msg_a, divreq_msg_b, divresp_rdy
  );
endinterface

// File: rtl/imuldiv_div_arbiter.sv
// Arbitrates two requesters onto one shared divider, exactly one transaction in flight.
// Optional feature: define IMULDIV_DIVARB_DIVZERO_EN to answer b == 0 locally with {a, 32'hFFFFFFFF}.
module imuldiv_div_arbiter #(
  parameter bit p_rr = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  imuldiv_div_arbiter_if.slave  io
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;
  typedef struct packed {
    logic        fn;
    logic [31:0] a;
    logic [31:0] b;
  } div_req_t;

  state_e          state_q, state_d;
  logic            last_q, last_d;
  logic            owner_q, owner_d;
  div_req_t        req_q, req_d;
  logic [63:0]     res_q, res_d;

  logic [1:0]      val, rdy, resp_rdy;
  div_req_t [1:0]  in_req;
  logic            gnt;

  assign val       = {io.req1_val, io.req0_val};
  assign resp_rdy  = {io.resp1_rdy, io.resp0_rdy};
  assign in_req[0] = '{fn: io.req0_fn, a: io.req0_a, b: io.req0_b};
  assign in_req[1] = '{fn: io.req1_fn, a: io.req1_a, b: io.req1_b};

  // Round-robin: a lone requester wins; on a tie the one not served last wins.
  always_comb begin
    gnt = 1'b0;
    if (p_rr) gnt = (val == 2'b10) ? 1'b1 : (val == 2'b01) ? 1'b0 : ~last_q;
    else      gnt = val[1] & ~val[0];
  end

  // Ready is masked by reset so nothing is offered while the block is held in reset.
  assign rdy = (state_q == IDLE && reset) ? (gnt ? 2'b10 : 2'b01) : 2'b00;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    owner_d = owner_q;
    req_d   = req_q;
    res_d   = res_q;
    case (state_q)
      IDLE: if (|(val & rdy)) begin
        req_d   = in_req[gnt];
        owner_d = gnt;
        last_d  = gnt;
`ifdef IMULDIV_DIVARB_DIVZERO_EN
        if (in_req[gnt].b == 32'd0) begin
          res_d   = {in_req[gnt].a, 32'hFFFF_FFFF};
          state_d = RESP;
        end else begin
          state_d = ISSUE;
        end
`else
        state_d = ISSUE;
`endif
      end
      ISSUE: if (io.divreq_rdy) state_d = WAIT;
      WAIT: if (io.divresp_val) begin
        res_d   = io.divresp_msg_result;
        state_d = RESP;
      end
      RESP: if (resp_rdy[owner_q]) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      owner_q <= 1'b0;
      req_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      req_q   <= req_d;
      res_q   <= res_d;
    end
  end

  assign io.req0_rdy      = rdy[0];
  assign io.req1_rdy      = rdy[1];
  assign io.divreq_val    = (state_q == ISSUE);
  assign io.divreq_msg_fn = req_q.fn;
  assign io.divreq_msg_a  = req_q.a;
  assign io.divreq_msg_b  = req_q.b;
  assign io.divresp_rdy   = (state_q == WAIT);
  assign io.resp0_val     = (state_q == RESP) && !owner_q;
  assign io.resp1_val     = (state_q == RESP) &&  owner_q;
  // Only the owner sees the result; the other bus is held at zero.
  assign io.resp0_result  = io.resp0_val ? res_q : 64'd0;
  assign io.resp1_result  = io.resp1_val ? res_q : 64'd0;
endmodule

// File: tb/tb_imuldiv_div_arbiter.sv
// Bench for imuldiv_div_arbiter: a round-robin and a fixed-priority instance, each behind a
// behavioural divider; grant order and results are predicted from plain arithmetic.
module tb_imuldiv_div_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  imuldiv_div_arbiter_if ifc [2] ();
  imuldiv_div_arbiter #(.p_rr(1'b1)) u_rr (.clk(clk), .reset(reset), .io(ifc[0].slave));
  imuldiv_div_arbiter #(.p_rr(1'b0)) u_fp (.clk(clk), .reset(reset), .io(ifc[1].slave));

  int checks = 0;
  int errors = 0;
  int lat = 1;
  int rr_last = 1;

  function automatic logic [63:0] div_ref(logic fn, logic [31:0] a, logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (fn) begin sa = $signed(a); sb = $signed(b); end
    else    begin sa = longint'({32'd0, a}); sb = longint'({32'd0, b}); end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Behavioural divider with a programmable latency, reset together with the arbiter.
  for (genvar g = 0; g < 2; g++) begin : g_div
    logic busy, gate;
    int   cnt;
    assign ifc[g].divreq_rdy = ~busy & gate;
    always @(posedge clk or negedge reset) begin
      if (!reset) begin
        busy <= 1'b0; gate <= 1'b0; cnt <= 0;
        ifc[g].divresp_val <= 1'b0;
        ifc[g].divresp_msg_result <= 64'd0;
      end else begin
        gate <= 1'($urandom_range(0, 1));
        if (!busy) begin
          if (ifc[g].divreq_val && ifc[g].divreq_rdy) begin
            busy <= 1'b1;
            cnt  <= lat;
            ifc[g].divresp_msg_result <= div_ref(ifc[g].divreq_msg_fn, ifc[g].divreq_msg_a, ifc[g].divreq_msg_b);
          end
        end else if (ifc[g].divresp_val) begin
          if (ifc[g].divresp_rdy) begin ifc[g].divresp_val <= 1'b0; busy <= 1'b0; end
        end else if (cnt > 0) cnt <= cnt - 1;
        else ifc[g].divresp_val <= 1'b1;
      end
    end
  end

  int          acc0[$], acc1[$], rid0[$];
  logic [63:0] rres0[$];
  bit          div_seen;
  logic [31:0] div_b;

  always @(posedge clk) begin
    if (ifc[0].req0_val && ifc[0].req0_rdy) acc0.push_back(0);
    if (ifc[0].req1_val && ifc[0].req1_rdy) acc0.push_back(1);
    if (ifc[1].req0_val && ifc[1].req0_rdy) acc1.push_back(0);
    if (ifc[1].req1_val && ifc[1].req1_rdy) acc1.push_back(1);
    if (ifc[0].resp0_val && ifc[0].resp0_rdy) begin rid0.push_back(0); rres0.push_back(ifc[0].resp0_result); end
    if (ifc[0].resp1_val && ifc[0].resp1_rdy) begin rid0.push_back(1); rres0.push_back(ifc[0].resp1_result); end
    if (ifc[0].divreq_val) begin div_seen = 1'b1; div_b = ifc[0].divreq_msg_b; end
  end

  logic        fn_t [2];
  logic [31:0] a_t  [2];
  logic [31:0] b_t  [2];

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic set_req(int k, bit v);
    if (k == 0) begin
      ifc[0].req0_val = v; ifc[0].req0_fn = fn_t[0]; ifc[0].req0_a = a_t[0]; ifc[0].req0_b = b_t[0];
    end else begin
      ifc[0].req1_val = v; ifc[0].req1_fn = fn_t[1]; ifc[0].req1_a = a_t[1]; ifc[0].req1_b = b_t[1];
    end
  endtask

  task automatic clear_inputs();
    for (int k = 0; k < 2; k++) begin fn_t[k] = 1'b0; a_t[k] = 32'd0; b_t[k] = 32'd1; set_req(k, 1'b0); end
    ifc[0].resp0_rdy = 1'b0; ifc[0].resp1_rdy = 1'b0;
    ifc[1].req0_val = 1'b0; ifc[1].req0_fn = 1'b0; ifc[1].req0_a = 32'd0; ifc[1].req0_b = 32'd1;
    ifc[1].req1_val = 1'b0; ifc[1].req1_fn = 1'b0; ifc[1].req1_a = 32'd0; ifc[1].req1_b = 32'd1;
    ifc[1].resp0_rdy = 1'b0; ifc[1].resp1_rdy = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    clear_inputs();
    cyc(); cyc();
    reset = 1'b1;
    rr_last = 1;
    acc0.delete(); acc1.delete(); rid0.delete(); rres0.delete();
  endtask

  // Drive the requesters in mask on the round-robin instance and check order and results.
  task automatic run(logic [1:0] mask, string tag);
    int order[$];
    int first, t;
    if (mask == 2'b11) begin first = 1 - rr_last; order = {first, 1 - first}; end
    else order = {(mask == 2'b10) ? 1 : 0};
    rr_last = order[order.size() - 1];
    acc0.delete(); rid0.delete(); rres0.delete();
    lat = $urandom_range(0, 3);
    for (int k = 0; k < 2; k++) if (mask[k]) set_req(k, 1'b1);
    t = 0;
    while (rid0.size() < order.size() && t < 300) begin
      cyc(); t++;
      for (int i = 0; i < acc0.size(); i++) set_req(acc0[i], 1'b0);
      if (acc0.size() > rid0.size())
        chk({tag, " rdy closed"}, 64'({ifc[0].req1_rdy, ifc[0].req0_rdy}), 64'd0);
      if (ifc[0].resp0_val) chk({tag, " resp1 idle"}, {ifc[0].resp1_val, ifc[0].resp1_result[62:0]}, 64'd0);
      if (ifc[0].resp1_val) chk({tag, " resp0 idle"}, {ifc[0].resp0_val, ifc[0].resp0_result[62:0]}, 64'd0);
      ifc[0].resp0_rdy = 1'($urandom_range(0, 1));
      ifc[0].resp1_rdy = 1'($urandom_range(0, 1));
    end
    set_req(0, 1'b0); set_req(1, 1'b0);
    ifc[0].resp0_rdy = 1'b0; ifc[0].resp1_rdy = 1'b0;
    chk({tag, " responses"}, 64'(rid0.size()), 64'(order.size()));
    for (int i = 0; i < order.size(); i++) begin
      chk($sformatf("%s grant%0d", tag, i), 64'(acc0[i]), 64'(order[i]));
      chk($sformatf("%s resp id%0d", tag, i), 64'(rid0[i]), 64'(order[i]));
      chk($sformatf("%s result%0d", tag, i), rres0[i], div_ref(fn_t[order[i]], a_t[order[i]], b_t[order[i]]));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t;
    int exp_w;
    clear_inputs();
    #1;
    chk("reset outs", 64'({ifc[0].req0_rdy, ifc[0].req1_rdy, ifc[0].resp0_val, ifc[0].resp1_val,
                           ifc[0].divreq_val, ifc[0].divresp_rdy}), 64'd0);
    chk("reset msg", {ifc[0].divreq_msg_a, ifc[0].divreq_msg_b}, 64'd0);
    cyc(); cyc();
    reset = 1'b1;
    set_req(1, 1'b1); #1;
    chk("lone req1 grant", 64'({ifc[0].req1_rdy, ifc[0].req0_rdy}), 64'd2);
    set_req(0, 1'b1); #1;
    chk("first tie grant", 64'({ifc[0].req1_rdy, ifc[0].req0_rdy}), 64'd1);
    set_req(1, 1'b0); #1;
    chk("lone req0 grant", 64'({ifc[0].req1_rdy, ifc[0].req0_rdy}), 64'd1);
    set_req(0, 1'b0);

    // Single unsigned request from requester 0.
    fn_t[0] = 1'b0; a_t[0] = 32'h0000_0007; b_t[0] = 32'h0000_0005;
    run(2'b01, "t1");
    chk("t1 const", rres0[0], 64'h00000002_00000001);

    // Simultaneous signed requests; requester 0 first after reset.
    do_reset();
    fn_t[0] = 1'b1; a_t[0] = 32'h0000_0064; b_t[0] = 32'h0000_0002;
    fn_t[1] = 1'b1; a_t[1] = 32'hFFFF_FF9C; b_t[1] = 32'h0000_0004;
    run(2'b11, "t2");
    chk("t2 const0", rres0[0], 64'h00000000_00000032);
    chk("t2 const1", rres0[1], 64'h00000000_FFFFFFE7);

    // Both requesters held valid for four transactions on both instances.
    do_reset();
    lat = 0;
    fn_t[0] = 1'b0; a_t[0] = 32'd100; b_t[0] = 32'd3;
    fn_t[1] = 1'b0; a_t[1] = 32'd200; b_t[1] = 32'd9;
    set_req(0, 1'b1); set_req(1, 1'b1);
    ifc[0].resp0_rdy = 1'b1; ifc[0].resp1_rdy = 1'b1;
    ifc[1].req0_a = 32'd50; ifc[1].req0_b = 32'd5; ifc[1].req1_a = 32'd60; ifc[1].req1_b = 32'd6;
    ifc[1].req0_val = 1'b1; ifc[1].req1_val = 1'b1;
    ifc[1].resp0_rdy = 1'b1; ifc[1].resp1_rdy = 1'b1;
    t = 0;
    while ((acc0.size() < 4 || acc1.size() < 4) && t < 400) begin
      cyc(); t++;
      if (acc0.size() >= 4) begin set_req(0, 1'b0); set_req(1, 1'b0); end
      if (acc1.size() >= 4) begin ifc[1].req0_val = 1'b0; ifc[1].req1_val = 1'b0; end
    end
    set_req(0, 1'b0); set_req(1, 1'b0);
    ifc[1].req0_val = 1'b0; ifc[1].req1_val = 1'b0;
    repeat (20) cyc();
    chk("hold rr count", 64'(acc0.size()), 64'd4);
    chk("hold fp count", 64'(acc1.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      exp_w = 1 - rr_last;
      rr_last = exp_w;
      chk($sformatf("hold rr grant%0d", i), 64'(acc0[i]), 64'(exp_w));
      chk($sformatf("hold fp grant%0d", i), 64'(acc1[i]), 64'd0);
    end
    ifc[0].resp0_rdy = 1'b0; ifc[0].resp1_rdy = 1'b0;
    ifc[1].resp0_rdy = 1'b0; ifc[1].resp1_rdy = 1'b0;

    // Response backpressure on requester 1 while requester 0 waits.
    do_reset();
    lat = 1;
    fn_t[1] = 1'b0; a_t[1] = 32'd1000; b_t[1] = 32'd7;
    set_req(1, 1'b1);
    t = 0; while (acc0.size() == 0 && t < 50) begin cyc(); t++; end
    set_req(1, 1'b0);
    t = 0; while (!ifc[0].resp1_val && t < 50) begin cyc(); t++; end
    chk("bp resp1_val", 64'(ifc[0].resp1_val), 64'd1);
    fn_t[0] = 1'b1; a_t[0] = 32'hFFFF_FFCE; b_t[0] = 32'd7;
    set_req(0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      #1;
      chk("bp held val", 64'(ifc[0].resp1_val), 64'd1);
      chk("bp held result", ifc[0].resp1_result, 64'h00000006_0000008E);
      chk("bp req0 blocked", 64'(ifc[0].req0_rdy), 64'd0);
      cyc();
    end
    ifc[0].resp1_rdy = 1'b1; cyc(); ifc[0].resp1_rdy = 1'b0;
    chk("bp released", 64'(rid0.size()), 64'd1);
    t = 0; while (acc0.size() < 2 && t < 50) begin cyc(); t++; end
    set_req(0, 1'b0);
    t = 0; while (!ifc[0].resp0_val && t < 50) begin cyc(); t++; end
    chk("bp req0 result", ifc[0].resp0_result, 64'hFFFFFFFF_FFFFFFF9);
    ifc[0].resp0_rdy = 1'b1; cyc(); ifc[0].resp0_rdy = 1'b0;
    rr_last = 0;

    // Divide by zero.
    fn_t[0] = 1'($urandom_range(0, 1)); a_t[0] = 32'h1234_5678; b_t[0] = 32'd0;
    div_seen = 1'b0;
    run(2'b01, "dz");
    chk("dz const", rres0[0], 64'h12345678_FFFFFFFF);
`ifdef IMULDIV_DIVARB_DIVZERO_EN
    chk("dz divider unused", 64'(div_seen), 64'd0);
`else
    chk("dz divider used", 64'(div_seen), 64'd1);
    chk("dz divider b", 64'(div_b), 64'd0);
`endif

    // Randomised traffic on the round-robin instance.
    for (int n = 0; n < 40; n++) begin
      for (int k = 0; k < 2; k++) begin
        fn_t[k] = 1'($urandom_range(0, 1));
        a_t[k]  = $urandom;
        b_t[k]  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 16)) : $urandom;
        if (b_t[k] == 32'd0) b_t[k] = 32'd1;
      end
      run(2'($urandom_range(1, 3)), $sformatf("rnd%0d", n));
    end

    // Reset while waiting on the divider abandons the transaction.
    do_reset();
    lat = 12;
    fn_t[1] = 1'b0; a_t[1] = 32'd5; b_t[1] = 32'd3;
    set_req(1, 1'b1);
    t = 0;
    while (!ifc[0].divresp_rdy && t < 50) begin
      cyc(); t++;
      if (acc0.size() > 0) set_req(1, 1'b0);
    end
    set_req(1, 1'b0);
    chk("rw in wait", 64'(ifc[0].divresp_rdy), 64'd1);
    reset = 1'b0; #1;
    chk("rw outs", 64'({ifc[0].req0_rdy, ifc[0].req1_rdy, ifc[0].resp0_val, ifc[0].resp1_val,
                        ifc[0].divreq_val, ifc[0].divresp_rdy}), 64'd0);
    chk("rw msg", {ifc[0].divreq_msg_a, ifc[0].divreq_msg_b}, 64'd0);
    chk("rw result", ifc[0].resp1_result, 64'd0);
    cyc(); cyc();
    reset = 1'b1;
    rr_last = 1;
    fn_t[1] = 1'b0; a_t[1] = 32'hFFFF_FFFF; b_t[1] = 32'h0000_0008;
    run(2'b10, "rw post");
    chk("rw post const", rres0[0], 64'h00000007_1FFFFFFF);
    repeat (30) cyc();
    chk("rw no stale", 64'(rid0.size()), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
